xc_malu_issue: RTL and testbench
================================

XC_MALU_ISSUE -- requirements
Module: xc_malu_issue

Interface
REQ-001 Parameter: TIMEOUT, default 80, maximum cycles spent in WAIT before the operation is abandoned.
REQ-002 Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  abandon the in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_op  in  4  operation code (package enum).
- req_pw  in  3  pack-width code: 0=32, 1=16, 2=8, 3=4, 4=2.
- req_rs1, req_rs2, req_rs3  in  32 each  operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rd  out  32  result word.
- rsp_err  out  1  illegal op, illegal pw, or timeout.
- malu_valid  out  1  one-cycle start strobe to the multi-cycle ALU.
- malu_flush  out  1  flush to the ALU.
- malu_uop  out  14  one-hot micro-op vector (package bit order).
- malu_pw  out  5  one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}.
- malu_rs1, malu_rs2, malu_rs3  out  32 each  held operands.
- malu_result  in  64  ALU result.
- malu_ready  in  1  ALU done.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-004 req_ready SHALL be high only in IDLE; on req_valid&&req_ready, op/pw/operands are registered and the FSM leaves IDLE.
REQ-005 Illegal op (code 15), or packed op with req_pw>4, SHALL go IDLE->RESP with rsp_err=1, rsp_rd=0, and no ALU activity.
REQ-006 DIV/DIVU with rs2==0 SHALL go IDLE->RESP with rsp_rd=32'hFFFFFFFF; REM/REMU with rs2==0 SHALL give rsp_rd=rs1; rsp_err=0, no ALU activity.
REQ-007 Otherwise IDLE->ISSUE; in ISSUE malu_valid=1 for exactly one cycle, then ->WAIT.
REQ-008 malu_uop, malu_pw and malu_rs* SHALL be stable from ISSUE through the cycle malu_ready is sampled, and zero in IDLE and RESP.
REQ-009 Non-packed ops SHALL drive malu_pw=5'b00001 regardless of req_pw.
REQ-010 In WAIT, malu_ready=1 SHALL capture the selected word into rsp_rd and go to RESP.
REQ-011 Word selection: DIV/DIVU/MUL/CLMUL/PMUL_L/PCLMUL_L -> result[31:0]; REM/REMU/MULH/MULHU/MULHSU/CLMULH/PMUL_H/PCLMUL_H -> result[63:32]; CLMULR -> result[62:31].
REQ-012 A WAIT cycle counter SHALL reset on entry; at count==TIMEOUT-1 without malu_ready, malu_flush SHALL pulse for one cycle and the FSM go to RESP with rsp_err=1, rsp_rd=0.
REQ-013 malu_ready and timeout in the same cycle: malu_ready SHALL win.
REQ-014 rsp_valid SHALL be high only in RESP; rsp_rd/rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then ->IDLE.
REQ-015 No new request SHALL be accepted in the RESP->IDLE cycle; latency from acceptance to rsp_valid is 1 cycle for bypass/error, and ALU cycles+2 otherwise.
REQ-016 flush in any state SHALL drive malu_flush=1 that cycle and return to IDLE next cycle with no response; flush overrides all other transitions.

Reset
REQ-017 reset SHALL set state IDLE, counter 0, rsp_rd 0, rsp_err 0, and all registered operand/op fields 0.
REQ-018 During and after reset: req_ready=0 while reset is high; rsp_valid=0, malu_valid=0, malu_uop=0, malu_pw=0, malu_rs*=0, malu_flush=1 while reset is high.

Structure
REQ-019 The op enum, uop bit indices, pw codes and the op->uop/word-select table SHALL live in shared package xc_malu_pkg.
REQ-020 The op/pw decode SHALL be a combinational sub-module xc_malu_issue_decode; the FSM and counter stay in the top.

Verification
REQ-021 MULHU rs1=32'hFFFFFFFF, rs2=2; model ALU ready after 33 cycles -> rsp_rd=1, rsp_err=0, malu_valid pulsed exactly once.
REQ-022 DIV rs1=7, rs2=0 -> rsp_valid 1 cycle after acceptance, rsp_rd=32'hFFFFFFFF, malu_valid never asserted; REMU rs1=7, rs2=0 -> rsp_rd=7.
REQ-023 req_op=15 -> rsp_err=1, rsp_rd=0; PMUL_L with req_pw=6 -> rsp_err=1.
REQ-024 ALU model never responds, TIMEOUT=80 -> malu_flush pulse in the 80th WAIT cycle, then rsp_err=1.
REQ-025 flush asserted in WAIT cycle 5 -> no response, IDLE next cycle; next MUL 3*5 -> rsp_rd=15.
REQ-026 rsp_ready held low 10 cycles in RESP -> rsp_rd stable throughout, req_ready=0 until the handshake completes.

Source files
------------

// File: rtl/xc_malu_pkg.sv
// Shared definitions for the multi-cycle ALU issue stage.
// Contents:
//   op_e        - 4-bit request operation code (15 is reserved/illegal)
//   UOP_*       - bit positions inside the 14-bit one-hot micro-op vector
//   PW_*        - request pack-width codes (0=32 .. 4=2 bits per lane)
//   sel_e       - which 32-bit window of the 64-bit ALU result is returned
//   op_info()   - op -> {uop, word select, packed flag, legal flag} table
//   select_word - applies a word select to a 64-bit ALU result
package xc_malu_pkg;

  typedef enum logic [3:0] {
    OP_DIV      = 4'd0,
    OP_DIVU     = 4'd1,
    OP_REM      = 4'd2,
    OP_REMU     = 4'd3,
    OP_MUL      = 4'd4,
    OP_MULH     = 4'd5,
    OP_MULHU    = 4'd6,
    OP_MULHSU   = 4'd7,
    OP_CLMUL    = 4'd8,
    OP_CLMULH   = 4'd9,
    OP_CLMULR   = 4'd10,
    OP_PMUL_L   = 4'd11,
    OP_PMUL_H   = 4'd12,
    OP_PCLMUL_L = 4'd13,
    OP_PCLMUL_H = 4'd14,
    OP_ILLEGAL  = 4'd15
  } op_e;

  localparam int UOP_W = 14;

  // CLMUL and CLMULH read the two halves of the same carry-less product,
  // so they share one micro-op; every other op has its own bit.
  localparam int UOP_DIV      = 0;
  localparam int UOP_DIVU     = 1;
  localparam int UOP_REM      = 2;
  localparam int UOP_REMU     = 3;
  localparam int UOP_MUL      = 4;
  localparam int UOP_MULH     = 5;
  localparam int UOP_MULHU    = 6;
  localparam int UOP_MULHSU   = 7;
  localparam int UOP_CLMUL    = 8;
  localparam int UOP_CLMULR   = 9;
  localparam int UOP_PMUL_L   = 10;
  localparam int UOP_PMUL_H   = 11;
  localparam int UOP_PCLMUL_L = 12;
  localparam int UOP_PCLMUL_H = 13;

  localparam int PW_W = 5;
  localparam logic [2:0] PW_32  = 3'd0;
  localparam logic [2:0] PW_16  = 3'd1;
  localparam logic [2:0] PW_8   = 3'd2;
  localparam logic [2:0] PW_4   = 3'd3;
  localparam logic [2:0] PW_2   = 3'd4;
  localparam logic [2:0] PW_MAX = PW_2;

  typedef enum logic [1:0] {
    SEL_LO  = 2'd0,
    SEL_HI  = 2'd1,
    SEL_MID = 2'd2
  } sel_e;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    sel_e             sel;
    logic             is_packed;
    logic             legal;
  } op_info_t;

  function automatic op_info_t op_info(input logic [3:0] op);
    op_info_t info;
    info.uop       = '0;
    info.sel       = SEL_LO;
    info.is_packed = 1'b0;
    info.legal     = 1'b1;
    case (op)
      OP_DIV:      begin info.uop[UOP_DIV]      = 1'b1; info.sel = SEL_LO;  end
      OP_DIVU:     begin info.uop[UOP_DIVU]     = 1'b1; info.sel = SEL_LO;  end
      OP_REM:      begin info.uop[UOP_REM]      = 1'b1; info.sel = SEL_HI;  end
      OP_REMU:     begin info.uop[UOP_REMU]     = 1'b1; info.sel = SEL_HI;  end
      OP_MUL:      begin info.uop[UOP_MUL]      = 1'b1; info.sel = SEL_LO;  end
      OP_MULH:     begin info.uop[UOP_MULH]     = 1'b1; info.sel = SEL_HI;  end
      OP_MULHU:    begin info.uop[UOP_MULHU]    = 1'b1; info.sel = SEL_HI;  end
      OP_MULHSU:   begin info.uop[UOP_MULHSU]   = 1'b1; info.sel = SEL_HI;  end
      OP_CLMUL:    begin info.uop[UOP_CLMUL]    = 1'b1; info.sel = SEL_LO;  end
      OP_CLMULH:   begin info.uop[UOP_CLMUL]    = 1'b1; info.sel = SEL_HI;  end
      OP_CLMULR:   begin info.uop[UOP_CLMULR]   = 1'b1; info.sel = SEL_MID; end
      OP_PMUL_L:   begin info.uop[UOP_PMUL_L]   = 1'b1; info.sel = SEL_LO;  info.is_packed = 1'b1; end
      OP_PMUL_H:   begin info.uop[UOP_PMUL_H]   = 1'b1; info.sel = SEL_HI;  info.is_packed = 1'b1; end
      OP_PCLMUL_L: begin info.uop[UOP_PCLMUL_L] = 1'b1; info.sel = SEL_LO;  info.is_packed = 1'b1; end
      OP_PCLMUL_H: begin info.uop[UOP_PCLMUL_H] = 1'b1; info.sel = SEL_HI;  info.is_packed = 1'b1; end
      default:     info.legal = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic [31:0] select_word(input sel_e sel, input logic [63:0] result);
    logic [31:0] word;
    case (sel)
      SEL_HI:  word = result[63:32];
      SEL_MID: word = result[62:31];
      default: word = result[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/xc_malu_issue_decode.sv
// Combinational op/pack-width decode for the ALU issue stage.
// Ports:
//   op, pw      - raw request op code and pack-width code
//   rs1, rs2    - request operands (for the divide-by-zero bypass)
//   uop         - one-hot micro-op
//   pw_oh       - one-hot pack width {pw_2,pw_4,pw_8,pw_16,pw_32}
//   sel         - word select (sel_e encoding)
//   illegal     - reserved op, or packed op with an out-of-range width
//   bypass      - divide/remainder by zero, answered without the ALU
//   bypass_rd   - result word for the bypass case
module xc_malu_issue_decode
  import xc_malu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [2:0]       pw,
  input  logic [31:0]      rs1,
  input  logic [31:0]      rs2,
  output logic [UOP_W-1:0] uop,
  output logic [PW_W-1:0]  pw_oh,
  output logic [1:0]       sel,
  output logic             illegal,
  output logic             bypass,
  output logic [31:0]      bypass_rd
);

  op_info_t info;
  logic     div_by_zero;

  always_comb begin
    info        = op_info(op);
    uop         = info.uop;
    sel         = info.sel;
    illegal     = !info.legal || (info.is_packed && (pw > PW_MAX));
    // Scalar ops always run at full word width whatever pw says.
    pw_oh       = info.is_packed ? (5'b00001 << pw) : 5'b00001;
    div_by_zero = (rs2 == 32'd0);
    bypass      = 1'b0;
    bypass_rd   = 32'd0;
    case (op)
      OP_DIV, OP_DIVU: begin
        bypass    = div_by_zero;
        bypass_rd = 32'hFFFF_FFFF;
      end
      OP_REM, OP_REMU: begin
        bypass    = div_by_zero;
        bypass_rd = rs1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xc_malu_issue.sv
// Issue/response sequencer in front of a multi-cycle ALU.
// Accepts one request at a time, either answers it locally (illegal op,
// divide by zero) or launches it on the ALU, waits for completion with a
// timeout, and holds the selected result word until it is consumed.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   flush                 - abandon the in-flight operation
//   req_*                 - request handshake, op, pack width, operands
//   rsp_*                 - response handshake, result word, error flag
//   malu_valid/flush      - start strobe and flush to the ALU
//   malu_uop/pw/rs1..3    - held micro-op, width and operands to the ALU
//   malu_result/ready     - ALU result and completion
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | one-cycle start strobe to the ALU
// WAIT  | waiting for malu_ready, timeout counter running
// RESP  | response presented until consumed
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter int TIMEOUT = 80
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [2:0]       req_pw,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_rs3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rd,
  output logic             rsp_err,
  output logic             malu_valid,
  output logic             malu_flush,
  output logic [UOP_W-1:0] malu_uop,
  output logic [PW_W-1:0]  malu_pw,
  output logic [31:0]      malu_rs1,
  output logic [31:0]      malu_rs2,
  output logic [31:0]      malu_rs3,
  input  logic [63:0]      malu_result,
  input  logic             malu_ready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [UOP_W-1:0] uop_q;
  logic [PW_W-1:0]  pw_q;
  logic [1:0]       sel_q;
  logic [31:0]      rs1_q, rs2_q, rs3_q;
  logic [31:0]      rd_q;
  logic             err_q;

  logic [UOP_W-1:0] dec_uop;
  logic [PW_W-1:0]  dec_pw;
  logic [1:0]       dec_sel;
  logic             dec_illegal, dec_bypass;
  logic [31:0]      dec_bypass_rd;

  xc_malu_issue_decode u_decode (
    .op        (req_op),
    .pw        (req_pw),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .uop       (dec_uop),
    .pw_oh     (dec_pw),
    .sel       (dec_sel),
    .illegal   (dec_illegal),
    .bypass    (dec_bypass),
    .bypass_rd (dec_bypass_rd)
  );

  logic active;
  logic timeout_hit;

  // ALU-facing fields are only visible while the ALU owns the operation.
  assign active      = !reset && ((state == S_ISSUE) || (state == S_WAIT));
  // A completing ALU in the last WAIT cycle beats the timeout.
  assign timeout_hit = (state == S_WAIT) && (cnt == CNT_LAST) && !malu_ready;

  assign req_ready  = !reset && !flush && (state == S_IDLE);
  assign rsp_valid  = !reset && !flush && (state == S_RESP);
  assign malu_valid = !reset && !flush && (state == S_ISSUE);
  assign malu_flush = reset || flush || timeout_hit;
  assign malu_uop   = active ? uop_q : '0;
  assign malu_pw    = active ? pw_q  : '0;
  assign malu_rs1   = active ? rs1_q : '0;
  assign malu_rs2   = active ? rs2_q : '0;
  assign malu_rs3   = active ? rs3_q : '0;
  assign rsp_rd     = rd_q;
  assign rsp_err    = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      uop_q <= '0;
      pw_q  <= '0;
      sel_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            uop_q <= dec_uop;
            pw_q  <= dec_pw;
            sel_q <= dec_sel;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            rs3_q <= req_rs3;
            if (dec_illegal) begin
              rd_q  <= '0;
              err_q <= 1'b1;
              state <= S_RESP;
            end else if (dec_bypass) begin
              rd_q  <= dec_bypass_rd;
              err_q <= 1'b0;
              state <= S_RESP;
            end else begin
              rd_q  <= '0;
              err_q <= 1'b0;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (malu_ready) begin
            rd_q  <= select_word(sel_e'(sel_q), malu_result);
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rd_q  <= '0;
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
module tb_xc_malu_issue;
  import xc_malu_pkg::*;

  localparam int TO = 80;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [2:0]  req_pw = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;
  logic        rsp_err;
  logic        malu_valid, malu_flush;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [63:0] malu_result = '0;
  logic        malu_ready = 1'b0;

  xc_malu_issue #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .malu_valid(malu_valid), .malu_flush(malu_flush), .malu_uop(malu_uop), .malu_pw(malu_pw),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_prints = 0;
  int n_malu_valid = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_prints < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      n_prints++;
    end
  endtask

  // Per-cycle expectations, set by the driver from the transaction model.
  bit          check_en = 1'b0;
  bit          e_req_ready, e_rsp_valid, e_malu_valid, e_malu_flush, e_active;
  logic [31:0] e_rd;
  bit          e_err;
  logic [13:0] e_uop;
  logic [4:0]  e_pw;
  logic [31:0] e_rs1, e_rs2, e_rs3;

  always @(negedge clock) begin
    #2;
    if (malu_valid === 1'b1) n_malu_valid++;
    if (check_en) begin
      chk("req_ready", req_ready, e_req_ready);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("malu_valid", malu_valid, e_malu_valid);
      chk("malu_flush", malu_flush, e_malu_flush);
      chk("malu_uop", malu_uop, e_active ? e_uop : 14'h0);
      chk("malu_pw", malu_pw, e_active ? e_pw : 5'h0);
      chk("malu_rs1", malu_rs1, e_active ? e_rs1 : 32'h0);
      chk("malu_rs2", malu_rs2, e_active ? e_rs2 : 32'h0);
      chk("malu_rs3", malu_rs3, e_active ? e_rs3 : 32'h0);
      if (e_rsp_valid) begin
        chk("rsp_rd", rsp_rd, e_rd);
        chk("rsp_err", rsp_err, e_err);
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic bit is_packed_op(input logic [3:0] op);
    return op inside {OP_PMUL_L, OP_PMUL_H, OP_PCLMUL_L, OP_PCLMUL_H};
  endfunction

  function automatic logic [13:0] uop_of(input logic [3:0] op);
    logic [13:0] one = 14'd1;
    int i;
    case (op)
      OP_DIV:      i = UOP_DIV;
      OP_DIVU:     i = UOP_DIVU;
      OP_REM:      i = UOP_REM;
      OP_REMU:     i = UOP_REMU;
      OP_MUL:      i = UOP_MUL;
      OP_MULH:     i = UOP_MULH;
      OP_MULHU:    i = UOP_MULHU;
      OP_MULHSU:   i = UOP_MULHSU;
      OP_CLMUL:    i = UOP_CLMUL;
      OP_CLMULH:   i = UOP_CLMUL;
      OP_CLMULR:   i = UOP_CLMULR;
      OP_PMUL_L:   i = UOP_PMUL_L;
      OP_PMUL_H:   i = UOP_PMUL_H;
      OP_PCLMUL_L: i = UOP_PCLMUL_L;
      default:     i = UOP_PCLMUL_H;
    endcase
    return one << i;
  endfunction

  // Reference ALU: real products for the multiply family, noise otherwise.
  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] noise);
    logic [63:0] sa, sb, za, zb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'h0, a};
    zb = {32'h0, b};
    case (op)
      OP_MUL, OP_MULH: return sa * sb;
      OP_MULHU:        return za * zb;
      OP_MULHSU:       return sa * zb;
      default:         return noise;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [3:0] op, input logic [63:0] r);
    if (op inside {OP_DIV, OP_DIVU, OP_MUL, OP_CLMUL, OP_PMUL_L, OP_PCLMUL_L}) return r[31:0];
    if (op == OP_CLMULR) return r[62:31];
    return r[63:32];
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_exp();
    e_req_ready  = 1'b1;
    e_rsp_valid  = 1'b0;
    e_malu_valid = 1'b0;
    e_malu_flush = 1'b0;
    e_active     = 1'b0;
  endtask

  task automatic junk_inputs();
    req_valid   = 1'($urandom);
    req_op      = 4'($urandom);
    req_pw      = 3'($urandom);
    req_rs1     = $urandom;
    req_rs2     = $urandom;
    req_rs3     = $urandom;
    rsp_ready   = 1'($urandom);
    malu_ready  = 1'b0;
    malu_result = {$urandom, $urandom};
    flush       = 1'b0;
  endtask

  // alu_lat: WAIT cycle in which the ALU completes (0 = never).
  // flush_w: WAIT cycle in which flush is raised (0 = none).
  task automatic txn(input logic [3:0] op, input logic [2:0] pw, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input int alu_lat, input int hold, input int flush_w,
                     output logic [31:0] m_rd, output bit m_err);
    bit          illegal, byp, uses_alu, timed_out;
    logic [63:0] res;
    int          end_w, start_cnt;
    illegal   = (op == OP_ILLEGAL) || (is_packed_op(op) && pw > 3'd4);
    byp       = !illegal && (b == 32'd0) && (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    uses_alu  = !illegal && !byp;
    timed_out = (alu_lat == 0) || (alu_lat > TO);
    end_w     = timed_out ? TO : alu_lat;
    res       = alu_model(op, a, b, {$urandom, $urandom});
    if (illegal) begin m_rd = 32'h0; m_err = 1'b1; end
    else if (byp) begin m_rd = (op inside {OP_DIV, OP_DIVU}) ? 32'hFFFF_FFFF : a; m_err = 1'b0; end
    else if (timed_out) begin m_rd = 32'h0; m_err = 1'b1; end
    else begin m_rd = pick(op, res); m_err = 1'b0; end
    start_cnt = n_malu_valid;

    tick();
    idle_exp();
    req_valid = 1'b1; req_op = op; req_pw = pw;
    req_rs1 = a; req_rs2 = b; req_rs3 = c;
    rsp_ready = 1'b0; malu_ready = 1'b0; flush = 1'b0;
    e_rd = m_rd; e_err = m_err;
    e_uop = uop_of(op);
    e_pw = is_packed_op(op) ? (5'b00001 << pw) : 5'b00001;
    e_rs1 = a; e_rs2 = b; e_rs3 = c;

    if (uses_alu) begin
      tick();
      junk_inputs();
      e_req_ready = 1'b0; e_malu_valid = 1'b1; e_active = 1'b1;
      for (int w = 1; w <= end_w; w++) begin
        tick();
        junk_inputs();
        e_malu_valid = 1'b0;
        if (w == alu_lat) begin
          malu_ready  = 1'b1;
          malu_result = res;
        end
        if (w == flush_w) begin
          flush = 1'b1;
          e_malu_flush = 1'b1;
          tick();
          req_valid = 1'b0; flush = 1'b0; malu_ready = 1'b0; rsp_ready = 1'b0;
          idle_exp();
          tick();
          chk("malu_valid_pulses", n_malu_valid - start_cnt, 1);
          return;
        end
        e_malu_flush = (w == TO) && (w != alu_lat);
      end
    end

    for (int h = 0; h <= hold; h++) begin
      tick();
      junk_inputs();
      e_req_ready = 1'b0; e_malu_valid = 1'b0; e_active = 1'b0;
      e_malu_flush = 1'b0; e_rsp_valid = 1'b1;
      rsp_ready = (h == hold);
    end
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0; malu_ready = 1'b0;
    idle_exp();
    chk("malu_valid_pulses", n_malu_valid - start_cnt, uses_alu ? 1 : 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          err;
    logic [3:0]  op;
    logic [2:0]  pw;
    logic [31:0] b;
    int          lat;

    // reset: ALU flush high, nothing valid, request channel closed
    e_req_ready = 1'b0; e_rsp_valid = 1'b0; e_malu_valid = 1'b0;
    e_malu_flush = 1'b1; e_active = 1'b0; e_rd = '0; e_err = 1'b0;
    e_uop = '0; e_pw = '0; e_rs1 = '0; e_rs2 = '0; e_rs3 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_en = 1'b1;
      req_valid = 1'b1; req_op = OP_MUL;
    end
    tick();
    reset = 1'b0; req_valid = 1'b0;
    idle_exp();
    tick();

    // directed cases with hand-computed results
    txn(OP_MULHU, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 33, 0, 0, rd, err);
    chk("pin_mulhu_rd", rd, 32'h1);
    chk("pin_mulhu_err", err, 0);
    txn(OP_DIV, 3'd0, 32'd7, 32'd0, 32'd0, 5, 0, 0, rd, err);
    chk("pin_div0_rd", rd, 32'hFFFF_FFFF);
    txn(OP_REMU, 3'd0, 32'd7, 32'd0, 32'd0, 5, 0, 0, rd, err);
    chk("pin_remu0_rd", rd, 32'd7);
    txn(OP_ILLEGAL, 3'd0, 32'h1234, 32'h5678, 32'h9, 5, 1, 0, rd, err);
    chk("pin_illegal_err", err, 1);
    chk("pin_illegal_rd", rd, 32'h0);
    txn(OP_PMUL_L, 3'd6, 32'h11, 32'h22, 32'h33, 5, 0, 0, rd, err);
    chk("pin_badpw_err", err, 1);
    txn(OP_MUL, 3'd0, 32'h10, 32'h20, 32'h0, 0, 0, 0, rd, err);
    chk("pin_timeout_err", err, 1);
    txn(OP_MUL, 3'd0, 32'h1234, 32'h10, 32'h0, TO, 0, 0, rd, err);
    chk("pin_ready_wins_rd", rd, 32'h12340);
    txn(OP_MUL, 3'd0, 32'd9, 32'd9, 32'd1, 20, 0, 5, rd, err);
    txn(OP_MUL, 3'd0, 32'd3, 32'd5, 32'd0, 4, 0, 0, rd, err);
    chk("pin_mul_rd", rd, 32'd15);
    txn(OP_MULH, 3'd0, 32'h8000_0000, 32'h3, 32'h0, 2, 10, 0, rd, err);
    chk("pin_mulh_rd", rd, 32'hFFFF_FFFE);
    txn(OP_CLMULR, 3'd1, $urandom, $urandom, $urandom, 1, 0, 0, rd, err);
    txn(OP_PMUL_H, 3'd4, $urandom, $urandom, $urandom, 3, 0, 0, rd, err);
    txn(OP_PCLMUL_L, 3'd2, $urandom, $urandom, $urandom, 6, 2, 0, rd, err);

    // flush while idle with a request pending: not accepted, no response
    tick();
    req_valid = 1'b1; req_op = OP_MUL; flush = 1'b1;
    e_req_ready = 1'b0; e_malu_flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    idle_exp();
    tick();
    tick();

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      op  = 4'($urandom);
      pw  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      lat = (t % 15 == 7) ? 0 : $urandom_range(1, 40);
      txn(op, pw, $urandom, b, $urandom, lat, $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0, rd, err);
    end

    tick();
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
